// File: rtl/dipsw_ioctl_port_if.sv
// ============================================================================
// Module      : dipsw_ioctl_port_if
// Description : HPS ioctl transfer signals shared by hps_io and the DIP bank.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface dipsw_ioctl_port_if;
    logic        ioctl_download;
    logic        ioctl_upload;
    logic [15:0] ioctl_index;
    logic [26:0] ioctl_addr;
    logic        ioctl_wr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_rd;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic        ioctl_upload_req;

    modport master (
        output ioctl_download, ioctl_upload, ioctl_index, ioctl_addr,
               ioctl_wr, ioctl_dout, ioctl_rd,
        input  ioctl_din, ioctl_wait, ioctl_upload_req
    );

    modport slave (
        input  ioctl_download, ioctl_upload, ioctl_index, ioctl_addr,
               ioctl_wr, ioctl_dout, ioctl_rd,
        output ioctl_din, ioctl_wait, ioctl_upload_req
    );
endinterface

`default_nettype wire

// File: rtl/dipsw_ioctl_port.sv
// ============================================================================
// Module      : dipsw_ioctl_port
// Description : DIP-switch bank with atomic ioctl download and read-back upload.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module dipsw_ioctl_port #(
    parameter int DIP_INDEX = 254,
    parameter int NBYTES    = 8,
    parameter int WAIT_CYC  = 1
) (
    input  wire logic                clk_sys,
    input  wire logic                reset_n,
    dipsw_ioctl_port_if.slave        ioctl,
    output logic [8*NBYTES-1:0]      dip_bank,
    output logic [7:0]               sw,
    output logic                     dip_valid
);

    localparam int LOG2N = (NBYTES > 1) ? $clog2(NBYTES) : 0;
    localparam int SELW  = (NBYTES > 1) ? LOG2N : 1;
    localparam int WCW   = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam logic [WCW-1:0] C_WAIT_LOAD = (WAIT_CYC > 0) ? WCW'(WAIT_CYC - 1) : '0;
    localparam logic [26:0]    C_CSUM_ADDR = 27'(NBYTES);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_COMMIT = 3'd2,
        ST_UPLOAD = 3'd3,
        ST_RWAIT  = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [NBYTES-1:0][7:0] r_stage;
    logic [NBYTES-1:0][7:0] r_bank;
    logic [7:0]             r_csum;
    logic [7:0]             w_csum;
    logic                   r_changed;
    logic                   r_valid;
    logic                   r_upload_req;
    logic [7:0]             r_din;
    logic                   r_wait;
    logic [WCW-1:0]         r_wait_cnt;
    logic [26:0]            r_rd_addr;
    logic                   r_rd_idx_ok;
    logic                   r_dl_q;
    logic                   r_ul_q;

    logic                   w_idx_match;
    logic                   w_in_range;
    logic                   w_hit;
    logic [SELW-1:0]        w_sel;
    logic                   w_dl_rise;
    logic                   w_ul_rise;
    logic                   w_go_load;
    logic                   w_rd_accept;

    assign w_idx_match = (ioctl.ioctl_index == 16'(DIP_INDEX));
    assign w_in_range  = ((ioctl.ioctl_addr >> LOG2N) == 27'd0);
    assign w_hit       = w_idx_match && w_in_range;
    assign w_sel       = ioctl.ioctl_addr[SELW-1:0];
    assign w_dl_rise   = ioctl.ioctl_download && !r_dl_q;
    assign w_ul_rise   = ioctl.ioctl_upload && !r_ul_q;

    // Upload read-back: bank bytes, then the checksum one past the end, zero elsewhere.
    function automatic logic [7:0] read_byte(input logic idx_ok, input logic [26:0] addr);
        logic [7:0] v;
        v = 8'h00;
        if (idx_ok && ((addr >> LOG2N) == 27'd0)) begin
            v = r_bank[addr[SELW-1:0]];
        end else if (idx_ok && (addr == C_CSUM_ADDR)) begin
            v = r_csum;
        end
        return v;
    endfunction

    always_comb begin
        w_csum = 8'h00;
        for (int k = 0; k < NBYTES; k++) begin
            w_csum = w_csum ^ r_stage[k];
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_go_load   = 1'b0;
        w_rd_accept = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Download wins when both transfers start on the same cycle.
                if (w_dl_rise && w_idx_match) begin
                    w_state_nxt = ST_LOAD;
                    w_go_load   = 1'b1;
                end else if (w_ul_rise && w_idx_match) begin
                    w_state_nxt = ST_UPLOAD;
                end
            end
            ST_LOAD: begin
                if (!ioctl.ioctl_download) begin
                    w_state_nxt = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                w_state_nxt = ST_IDLE;
            end
            ST_UPLOAD: begin
                if (!ioctl.ioctl_upload) begin
                    w_state_nxt = ST_IDLE;
                end else if (ioctl.ioctl_rd) begin
                    w_rd_accept = 1'b1;
                    if (WAIT_CYC != 0) begin
                        w_state_nxt = ST_RWAIT;
                    end
                end
            end
            ST_RWAIT: begin
                if (!ioctl.ioctl_upload) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_wait_cnt == '0) begin
                    w_state_nxt = ST_UPLOAD;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Edge history resets high so a line still asserted across reset is not a new transfer.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_dl_q <= 1'b1;
            r_ul_q <= 1'b1;
        end else begin
            r_dl_q <= ioctl.ioctl_download;
            r_ul_q <= ioctl.ioctl_upload;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_stage      <= '0;
            r_bank       <= '0;
            r_csum       <= 8'h00;
            r_changed    <= 1'b0;
            r_valid      <= 1'b0;
            r_upload_req <= 1'b0;
            r_din        <= 8'h00;
            r_wait       <= 1'b0;
            r_wait_cnt   <= '0;
            r_rd_addr    <= '0;
            r_rd_idx_ok  <= 1'b0;
        end else begin
            r_upload_req <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_go_load) begin
                        r_stage   <= r_bank;
                        r_changed <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (ioctl.ioctl_wr && w_hit) begin
                        r_stage[w_sel] <= ioctl.ioctl_dout;
                        if (ioctl.ioctl_dout != r_bank[w_sel]) begin
                            r_changed <= 1'b1;
                        end
                    end
                end
                ST_COMMIT: begin
                    r_bank       <= r_stage;
                    r_valid      <= 1'b1;
                    r_csum       <= w_csum;
                    r_upload_req <= r_changed;
                end
                ST_UPLOAD: begin
                    if (w_rd_accept) begin
                        if (WAIT_CYC == 0) begin
                            r_din <= read_byte(w_idx_match, ioctl.ioctl_addr);
                        end else begin
                            r_rd_addr   <= ioctl.ioctl_addr;
                            r_rd_idx_ok <= w_idx_match;
                            r_wait      <= 1'b1;
                            r_wait_cnt  <= C_WAIT_LOAD;
                        end
                    end
                end
                ST_RWAIT: begin
                    if (!ioctl.ioctl_upload) begin
                        r_wait <= 1'b0;
                    end else if (r_wait_cnt == '0) begin
                        r_wait <= 1'b0;
                        r_din  <= read_byte(r_rd_idx_ok, r_rd_addr);
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 1'b1;
                    end
                end
                default: begin
                    r_wait <= 1'b0;
                end
            endcase
        end
    end

    assign dip_bank               = r_bank;
    assign sw                     = r_bank[0];
    assign dip_valid              = r_valid;
    assign ioctl.ioctl_din        = r_din;
    assign ioctl.ioctl_wait       = r_wait;
    assign ioctl.ioctl_upload_req = r_upload_req;

endmodule

`default_nettype wire

// File: tb/tb_dipsw_ioctl_port.sv
// ============================================================================
// Module      : tb_dipsw_ioctl_port
// Description : Directed self-checking bench for the DIP-switch ioctl port.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dipsw_ioctl_port;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic [63:0] dip_bank;
    logic [7:0]  sw;
    logic        dip_valid;

    int n_checks = 0;
    int n_pass   = 0;

    logic [26:0] wa [8];
    logic [7:0]  wd [8];

    dipsw_ioctl_port_if bus ();

    dipsw_ioctl_port #(
        .DIP_INDEX (254),
        .NBYTES    (8),
        .WAIT_CYC  (1)
    ) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .ioctl     (bus.slave),
        .dip_bank  (dip_bank),
        .sw        (sw),
        .dip_valid (dip_valid)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Bank must stay at old_bank through LOAD and the COMMIT cycle, then switch in one step.
    task automatic do_download(input string tag, input logic [15:0] idx, input int n,
                               input logic [63:0] old_bank, input logic [63:0] new_bank,
                               input logic exp_req);
        bus.ioctl_index    = idx;
        bus.ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < n; i++) begin
            bus.ioctl_addr = wa[i];
            bus.ioctl_dout = wd[i];
            bus.ioctl_wr   = 1'b1;
            tick();
            bus.ioctl_wr   = 1'b0;
        end
        check({tag, " mid bank"}, dip_bank, old_bank);
        check({tag, " mid sw"}, {56'd0, sw}, {56'd0, old_bank[7:0]});
        bus.ioctl_download = 1'b0;
        tick();
        check({tag, " commit-cycle bank"}, dip_bank, old_bank);
        tick();
        check({tag, " bank"}, dip_bank, new_bank);
        check({tag, " sw"}, {56'd0, sw}, {56'd0, new_bank[7:0]});
        check({tag, " req"}, {63'd0, bus.ioctl_upload_req}, {63'd0, exp_req});
        tick();
        check({tag, " req end"}, {63'd0, bus.ioctl_upload_req}, 64'd0);
        bus.ioctl_index = 16'd254;
    endtask

    task automatic read_chk(input logic [26:0] a, input logic [7:0] exp);
        bus.ioctl_addr = a;
        bus.ioctl_rd   = 1'b1;
        tick();
        bus.ioctl_rd   = 1'b0;
        check($sformatf("rd%0d wait hi", a), {63'd0, bus.ioctl_wait}, 64'd1);
        tick();
        check($sformatf("rd%0d wait lo", a), {63'd0, bus.ioctl_wait}, 64'd0);
        check($sformatf("rd%0d din", a), {56'd0, bus.ioctl_din}, {56'd0, exp});
    endtask

    initial begin
        bus.ioctl_download = 1'b0;
        bus.ioctl_upload   = 1'b0;
        bus.ioctl_index    = 16'd254;
        bus.ioctl_addr     = '0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_dout     = 8'h00;
        bus.ioctl_rd       = 1'b0;
        tick();
        tick();
        check("rst bank", dip_bank, 64'd0);
        check("rst sw", {56'd0, sw}, 64'd0);
        check("rst valid", {63'd0, dip_valid}, 64'd0);
        check("rst wait", {63'd0, bus.ioctl_wait}, 64'd0);
        check("rst req", {63'd0, bus.ioctl_upload_req}, 64'd0);
        check("rst din", {56'd0, bus.ioctl_din}, 64'd0);
        reset_n = 1'b1;
        tick();
        tick();

        for (int i = 0; i < 8; i++) begin
            wa[i] = 27'(i);
            wd[i] = 8'(i + 1);
        end
        do_download("dl1", 16'd254, 8, 64'd0, 64'h0807060504030201, 1'b1);
        check("dl1 valid", {63'd0, dip_valid}, 64'd1);
        do_download("dl_same", 16'd254, 8, 64'h0807060504030201, 64'h0807060504030201, 1'b0);

        bus.ioctl_upload = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) read_chk(27'(i), 8'(i + 1));
        read_chk(27'd8, 8'h08);
        read_chk(27'd9, 8'h00);

        // A strobe while stalled must not start a second read.
        bus.ioctl_addr = 27'd3;
        bus.ioctl_rd   = 1'b1;
        tick();
        bus.ioctl_addr = 27'd5;
        tick();
        bus.ioctl_rd   = 1'b0;
        check("rd busy din", {56'd0, bus.ioctl_din}, 64'h04);
        check("rd busy wait", {63'd0, bus.ioctl_wait}, 64'd0);
        tick();
        check("rd busy wait2", {63'd0, bus.ioctl_wait}, 64'd0);
        check("rd busy din2", {56'd0, bus.ioctl_din}, 64'h04);

        bus.ioctl_addr = 27'd0;
        bus.ioctl_rd   = 1'b1;
        tick();
        bus.ioctl_rd     = 1'b0;
        bus.ioctl_upload = 1'b0;
        tick();
        check("ul abort wait", {63'd0, bus.ioctl_wait}, 64'd0);
        bus.ioctl_addr = 27'd6;
        bus.ioctl_rd   = 1'b1;
        tick();
        bus.ioctl_rd   = 1'b0;
        tick();
        check("rd idle ignored", {56'd0, bus.ioctl_din}, 64'h04);

        wa[0] = 27'd2;
        wd[0] = 8'hFF;
        do_download("dl_b2", 16'd254, 1, 64'h0807060504030201, 64'h0807060504FF0201, 1'b1);

        wa[0] = 27'd0;
        wd[0] = 8'hAA;
        do_download("dl_idx0", 16'd0, 1, 64'h0807060504FF0201, 64'h0807060504FF0201, 1'b0);
        wa[0] = 27'h10;
        do_download("dl_oob", 16'd254, 1, 64'h0807060504FF0201, 64'h0807060504FF0201, 1'b0);

        bus.ioctl_index    = 16'd254;
        bus.ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            bus.ioctl_addr = 27'(i);
            bus.ioctl_dout = 8'hA0 + 8'(i);
            bus.ioctl_wr   = 1'b1;
            tick();
            bus.ioctl_wr   = 1'b0;
        end
        #2;
        reset_n = 1'b0;
        #1;
        check("arst bank", dip_bank, 64'd0);
        check("arst valid", {63'd0, dip_valid}, 64'd0);
        check("arst din", {56'd0, bus.ioctl_din}, 64'd0);
        tick();
        tick();
        reset_n = 1'b1;
        bus.ioctl_addr = 27'd0;
        bus.ioctl_dout = 8'h55;
        bus.ioctl_wr   = 1'b1;
        tick();
        bus.ioctl_wr   = 1'b0;
        tick();
        bus.ioctl_download = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post-rst req", {63'd0, bus.ioctl_upload_req}, 64'd0);
        end
        check("post-rst bank", dip_bank, 64'd0);
        check("post-rst valid", {63'd0, dip_valid}, 64'd0);

        wa[0] = 27'd0;
        wd[0] = 8'h11;
        do_download("dl_fresh", 16'd254, 1, 64'd0, 64'h0000000000000011, 1'b1);
        check("dl_fresh valid", {63'd0, dip_valid}, 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dipsw_ioctl_port.md
Name: dipsw_ioctl_port

Overview:
- Owns the 8-byte DIP-switch bank for the arcade core.
- Accepts HPS ioctl downloads on the DIP index and commits them atomically to the game logic.
- Serves ioctl uploads (read-back) of the committed bank plus a checksum byte, so the HPS can save current settings.
- Sits between hps_io and space_race_top; replaces the inline dipsw array in emu.

Parameters:
- DIP_INDEX, 254, ioctl_index value selecting the DIP bank for download and upload.
- NBYTES, 8, bank size in bytes; must be a power of two, 1..8.
- WAIT_CYC, 1, ioctl_wait assertion cycles per upload read; 0 disables wait.

Ports:
- clk_sys  in  1  system clock (57.272 MHz)
- reset_n  in  1  asynchronous active-low reset
- ioctl_download  in  1  HPS download in progress
- ioctl_upload  in  1  HPS upload in progress
- ioctl_index  in  16  selected ioctl index
- ioctl_addr  in  27  byte address
- ioctl_wr  in  1  download byte strobe, one cycle
- ioctl_dout  in  8  download data
- ioctl_rd  in  1  upload byte strobe, one cycle
- ioctl_din  out  8  upload data
- ioctl_wait  out  1  stall request to HPS during upload read
- ioctl_upload_req  out  1  one-cycle pulse requesting the HPS to save settings
- dip_bank  out  8*NBYTES  committed bank; byte k at bits [8k+7:8k]
- sw  out  8  committed byte 0 (COINAGE/PLAYTIME)
- dip_valid  out  1  high once at least one download has been committed

Behaviour:
- Reset (asynchronous, reset_n low) clears:
  - staging bank, dip_bank, sw, ioctl_din to 0
  - ioctl_wait, ioctl_upload_req, dip_valid to 0
  - checksum to 0; state to IDLE.
- Address decode: `hit = (ioctl_index == DIP_INDEX) && (ioctl_addr[26:$clog2(NBYTES)] == 0)`. Addresses outside the bank are ignored on write; on read they return 8'h00, except the checksum address below.
- FSM states: IDLE, LOAD, COMMIT, UPLOAD, RWAIT.
- IDLE:
  - ioctl_download rise with index == DIP_INDEX → LOAD; the staging bank is preloaded with dip_bank, so unwritten bytes keep their values.
  - ioctl_upload rise with index == DIP_INDEX → UPLOAD.
  - Other indices are ignored; the FSM stays in IDLE.
- LOAD:
  - ioctl_wr && hit writes ioctl_dout into staging[addr]; the last write to the same address wins.
  - Each hit write sets a per-transfer "changed" flag if the new value differs from the dip_bank byte.
  - ioctl_download fall → COMMIT.
- COMMIT (exactly one cycle):
  - dip_bank <= staging; sw <= staging[0]; dip_valid <= 1.
  - checksum <= XOR of all staging bytes.
  - → IDLE.
  - dip_bank and sw never show a partially loaded bank.
- UPLOAD:
  - On ioctl_rd: if WAIT_CYC == 0, ioctl_din is updated the next cycle.
  - Otherwise ioctl_wait rises the cycle after ioctl_rd, stays high WAIT_CYC cycles (RWAIT), then ioctl_din is valid and ioctl_wait falls in the same cycle.
  - Read data:
    - addr < NBYTES → dip_bank byte.
    - addr == NBYTES (index matched, all higher bits 0) → checksum.
    - All other addresses → 8'h00.
  - ioctl_upload fall → IDLE, even from RWAIT; ioctl_wait clears immediately.
  - ioctl_rd while ioctl_wait is high is ignored.
- ioctl_upload_req: one-cycle pulse, issued the cycle after COMMIT, only if "changed" was set during that LOAD. A download of identical data produces no pulse.
- Simultaneous events:
  - download and upload rising together in IDLE → download has priority.
  - ioctl_wr outside LOAD is ignored.
  - ioctl_rd outside UPLOAD/RWAIT is ignored.
- Download abort: a LOAD that ends by reset discards staging; dip_bank is unchanged until reset clears it.
- reset_n asserted mid-transfer: all state clears asynchronously; after release the FSM waits in IDLE for a fresh rising edge. A still-high ioctl_download does not restart LOAD.

Test Plan:
- Reset, then download 8 bytes 01..08 at index 254 → 1 cycle after ioctl_download fall:
  - dip_bank = 64'h0807060504030201, sw = 8'h01, dip_valid = 1.
  - ioctl_upload_req pulses once, the next cycle.
- During that download, sample sw mid-transfer → sw remains 0 until the COMMIT cycle; no partial bytes are visible.
- Re-download identical bytes → dip_bank unchanged, no ioctl_upload_req pulse. Download only addr 2 = 8'hFF → dip_bank byte2 = FF, others kept, pulse issued.
- Upload with WAIT_CYC = 1, read addrs 0..8 then 9 →
  - each read: ioctl_wait high exactly 1 cycle, then ioctl_din = 01..08.
  - addr 8 returns checksum 8'h08 (XOR of 01..08).
  - addr 9 returns 00.
- Download at index 0 with addr 0 = 8'hAA, plus index 254 with addr 27'h10 → dip_bank unchanged, no pulse.
- Assert reset_n low mid-LOAD after 3 writes, release with ioctl_download still high → all outputs 0, FSM stays IDLE, later writes ignored until a new download edge.
